// File: rtl/tick_sched_pkg.sv
// Shared types and helpers for the tick scheduler.
// State encoding for the request FSM and the gap counter saturation value.
package tick_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ERR  = 2'd2
  } state_t;

  // Largest value a gap counter of the given width can hold.
  function automatic int unsigned gap_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/tick_gap_monitor.sv
// Inter-tick gap monitor: a saturating cycle counter that is reloaded on
// every tick, and a one-cycle glitch pulse for ticks that arrive fewer than
// MIN_GAP cycles after the previous one. Reset saturates the counter so the
// first tick afterwards can never glitch.
module tick_gap_monitor
  import tick_sched_pkg::*;
#(
  parameter int MIN_GAP  = 8,
  parameter int GAP_BITS = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  output logic glitch
);

  localparam int unsigned GAP_MAX = gap_max(GAP_BITS);
  localparam logic [GAP_BITS-1:0] GAP_SAT = GAP_MAX[GAP_BITS-1:0];
  // The counter reads distance-1 at the second tick, hence MIN_GAP-1.
  localparam logic [GAP_BITS-1:0] GAP_THR = GAP_BITS'(MIN_GAP - 1);

  logic [GAP_BITS-1:0] gap;

  // Count cycles since the last tick (saturating) and flag short gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap    <= GAP_SAT;
      glitch <= 1'b0;
    end else begin
      glitch <= tick && (gap < GAP_THR);
      if (tick) begin
        gap <= '0;
      end else if (gap != GAP_SAT) begin
        gap <= gap + GAP_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Tick scheduler: counts TICKS_PER_REQ upstream ticks, then raises a level
// request and waits for ack. If ACK_TIMEOUT ticks pass without ack it parks
// in ERR with a sticky timeout until clr. A gap monitor flags ticks that
// arrive too close together. All outputs are registered.
// Optional build macro: TICK_SCHED_ASSERT_EN adds concurrent assertions.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int TICKS_PER_REQ = 4,
  parameter int TICK_BITS     = 3,
  parameter int ACK_TIMEOUT   = 2,
  parameter int MIN_GAP       = 8,
  parameter int GAP_BITS      = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 ack,
  input  logic                 clr,
  output logic                 req,
  output logic                 busy,
  output logic                 timeout,
  output logic                 glitch,
  output logic [TICK_BITS-1:0] tick_cnt
);

  localparam logic [TICK_BITS-1:0] LAST_TICK = TICK_BITS'(TICKS_PER_REQ - 1);
  localparam logic [TICK_BITS-1:0] LAST_WAIT = TICK_BITS'(ACK_TIMEOUT - 1);
  // A tick coinciding with ack opens the next window; with a one-tick window
  // it cannot be carried, since the counter must stay below TICKS_PER_REQ.
  localparam logic [TICK_BITS-1:0] ACK_TICK_CNT =
    TICK_BITS'((TICKS_PER_REQ > 1) ? 1 : 0);

  state_t               state, state_n;
  logic [TICK_BITS-1:0] tick_cnt_n;
  logic [TICK_BITS-1:0] wait_cnt, wait_cnt_n;

  tick_gap_monitor #(
    .MIN_GAP  (MIN_GAP),
    .GAP_BITS (GAP_BITS)
  ) u_gap (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .glitch (glitch)
  );

  // Next-state and counter update for the request handshake.
  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    wait_cnt_n = wait_cnt;
    case (state)
      IDLE: begin
        if (tick) begin
          if (tick_cnt == LAST_TICK) begin
            state_n    = REQ;
            tick_cnt_n = '0;
            wait_cnt_n = '0;
          end else begin
            tick_cnt_n = tick_cnt + TICK_BITS'(1);
          end
        end
      end
      REQ: begin
        if (ack) begin
          state_n    = IDLE;
          tick_cnt_n = tick ? ACK_TICK_CNT : '0;
          wait_cnt_n = '0;
        end else if (tick) begin
          if (wait_cnt == LAST_WAIT) begin
            state_n    = ERR;
            tick_cnt_n = '0;
            wait_cnt_n = '0;
          end else begin
            wait_cnt_n = wait_cnt + TICK_BITS'(1);
          end
        end
      end
      ERR: begin
        tick_cnt_n = '0;
        wait_cnt_n = '0;
        if (clr) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n    = IDLE;
        tick_cnt_n = '0;
        wait_cnt_n = '0;
      end
    endcase
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      wait_cnt <= '0;
      req      <= 1'b0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      wait_cnt <= wait_cnt_n;
      req      <= (state_n == REQ);
      busy     <= (state_n != IDLE);
      timeout  <= (state_n == ERR);
    end
  end

`ifdef TICK_SCHED_ASSERT_EN
  a_req_no_timeout: assert property (@(posedge clk) disable iff (rst)
    req |-> !timeout);
  a_glitch_single: assert property (@(posedge clk) disable iff (rst)
    glitch |=> !glitch);
  a_tick_cnt_range: assert property (@(posedge clk) disable iff (rst)
    tick_cnt < TICK_BITS'(TICKS_PER_REQ));
  a_liveness: assert property (@(posedge clk)
    (always (s_eventually rst)) or (s_eventually always (!busy s_until req)));
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: directed scenarios followed by random
// tick/ack/clr traffic, all checked against a transaction-level model of
// the request windows and of tick-to-tick distances.
module tb_tick_scheduler;

  localparam int TPR = 4;
  localparam int AT  = 2;
  localparam int MG  = 8;
  localparam int TB  = 3;

  localparam int P_WAITING = 0;
  localparam int P_ASKING  = 1;
  localparam int P_FAULTED = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic ack = 1'b0;
  logic clr = 1'b0;
  logic req, busy, timeout, glitch;
  logic [TB-1:0] tick_cnt;

  tick_scheduler #(
    .TICKS_PER_REQ (TPR),
    .TICK_BITS     (TB),
    .ACK_TIMEOUT   (AT),
    .MIN_GAP       (MG),
    .GAP_BITS      (14)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .ack      (ack),
    .clr      (clr),
    .req      (req),
    .busy     (busy),
    .timeout  (timeout),
    .glitch   (glitch),
    .tick_cnt (tick_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model
  int     m_phase;
  int     m_window;
  int     m_waited;
  bit     m_seen;
  longint m_last;
  longint cyc = 0;
  bit     m_glitch;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase  = P_WAITING;
    m_window = 0;
    m_waited = 0;
    m_seen   = 1'b0;
    m_glitch = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model, then compare all outputs.
  task automatic step(input bit t, input bit a, input bit c);
    tick = t;
    ack  = a;
    clr  = c;
    @(posedge clk);
    cyc++;
    m_glitch = t && m_seen && ((cyc - m_last) < MG);
    if (t) begin
      m_seen = 1'b1;
      m_last = cyc;
    end
    if (m_phase == P_WAITING) begin
      if (t) begin
        m_window++;
        if (m_window == TPR) begin
          m_phase  = P_ASKING;
          m_window = 0;
          m_waited = 0;
        end
      end
    end else if (m_phase == P_ASKING) begin
      if (a) begin
        m_phase  = P_WAITING;
        m_window = (t && TPR > 1) ? 1 : 0;
      end else if (t) begin
        m_waited++;
        if (m_waited == AT) m_phase = P_FAULTED;
      end
    end else begin
      if (c) begin
        m_phase  = P_WAITING;
        m_window = 0;
      end
    end
    #1;
    tick = 1'b0;
    ack  = 1'b0;
    clr  = 1'b0;
    check("req", req, m_phase == P_ASKING);
    check("busy", busy, m_phase != P_WAITING);
    check("timeout", timeout, m_phase == P_FAULTED);
    check("glitch", glitch, m_glitch);
    check("tick_cnt", tick_cnt, m_window);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Tick now, then n quiet cycles.
  task automatic tick_gap(input int n);
    step(1'b1, 1'b0, 1'b0);
    idle(n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    check("rst_req", req, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    check("rst_glitch", glitch, 0);
    check("rst_tick_cnt", tick_cnt, 0);
    #1 rst = 1'b0;

    // Window of four ticks, then ack.
    tick_gap(19);
    tick_gap(19);
    tick_gap(19);
    step(1'b1, 1'b0, 1'b0);
    check("req_after_4", req, 1);
    check("busy_after_4", busy, 1);
    idle(4);
    step(1'b0, 1'b1, 1'b0);
    check("req_after_ack", req, 0);
    check("cnt_after_ack", tick_cnt, 0);

    // Timeout path, ignored ticks in ERR, clr.
    idle(19);
    for (int i = 0; i < 4; i++) tick_gap(19);
    tick_gap(19);
    step(1'b1, 1'b0, 1'b0);
    check("timeout_set", timeout, 1);
    check("req_in_err", req, 0);
    idle(19);
    tick_gap(19);
    step(1'b1, 1'b0, 1'b0);
    check("cnt_in_err", tick_cnt, 0);
    idle(3);
    step(1'b0, 1'b0, 1'b1);
    check("timeout_clr", timeout, 0);
    check("busy_clr", busy, 0);

    // Ack and tick in the same cycle after one wait tick.
    idle(19);
    for (int i = 0; i < 4; i++) tick_gap(19);
    tick_gap(19);
    step(1'b1, 1'b1, 1'b0);
    check("ack_tick_cnt", tick_cnt, 1);
    check("ack_tick_timeout", timeout, 0);
    check("ack_tick_req", req, 0);

    // Glitch at distance 5, none at distance 8.
    idle(30);
    tick_gap(4);
    step(1'b1, 1'b0, 1'b0);
    check("glitch_d5", glitch, 1);
    idle(1);
    check("glitch_pulse_end", glitch, 0);
    idle(6);
    step(1'b1, 1'b0, 1'b0);
    check("glitch_d8", glitch, 0);

    // Async reset mid-REQ.
    idle(19);
    step(1'b0, 1'b1, 1'b1);
    idle(19);
    for (int i = 0; i < 2 * TPR && !req; i++) tick_gap((i < 2 * TPR - 1 && !req) ? 0 : 0);
    check("req_before_rst", req, 1);
    #3 rst = 1'b1;
    #1;
    check("async_req", req, 0);
    check("async_busy", busy, 0);
    check("async_timeout", timeout, 0);
    check("async_cnt", tick_cnt, 0);
    model_reset();
    #2 rst = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    check("first_tick_no_glitch", glitch, 0);
    idle(19);
    tick_gap(19);
    step(1'b1, 1'b0, 1'b0);
    check("req_3_after_rst", req, 0);
    idle(19);
    step(1'b1, 1'b0, 1'b0);
    check("req_4_after_rst", req, 1);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
